// File: rtl/quad_pkg.sv
// Shared definitions for the quadratic MAC front end: default widths and the
// frame-parser state encoding used by the loader and the MAC bench.
package quad_pkg;

   localparam int QUAD_DATA_W = 8;
   localparam int QUAD_CNT_W  = 8;

   typedef enum logic [1:0] {
      ST_A = 2'd0,
      ST_B = 2'd1,
      ST_C = 2'd2,
      ST_X = 2'd3
   } state_t;

endpackage

// File: rtl/quad_operand_loader.sv
// Parses a/b/c/x... byte frames from a valid/ready stream and issues one
// operand set per x sample to the quadratic MAC, with an issue counter and error flag.
module quad_operand_loader
   import quad_pkg::*;
#(
   parameter int DATA_W = quad_pkg::QUAD_DATA_W,
   parameter int CNT_W  = quad_pkg::QUAD_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   input  logic              s_last,
   output logic              s_ready,
   input  logic              stall,
   output logic [DATA_W-1:0] in_a,
   output logic [DATA_W-1:0] in_b,
   output logic [DATA_W-1:0] in_c,
   output logic [DATA_W-1:0] in_x,
   output logic              enable,
   output logic [CNT_W-1:0]  eval_cnt,
   output logic              err,
   output logic              busy
);

   state_t            state;
   logic [DATA_W-1:0] sh_a;
   logic [DATA_W-1:0] sh_b;
   logic [DATA_W-1:0] sh_c;
   logic              fire;
   logic              issue;

   // Stall only gates acceptance of x samples; coefficients always flow in.
   assign s_ready = reset & ((state != ST_X) | ~stall);
   assign fire    = s_valid & s_ready;
   assign issue   = fire & (state == ST_X);
   assign busy    = (state != ST_A);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_A;
         sh_a  <= '0;
         sh_b  <= '0;
         sh_c  <= '0;
         err   <= 1'b0;
      end else if (fire) begin
         case (state)
            ST_A: begin
               sh_a <= s_data;
               if (s_last) err <= 1'b1;
               else        state <= ST_B;
            end
            ST_B: begin
               sh_b <= s_data;
               if (s_last) begin
                  err   <= 1'b1;
                  state <= ST_A;
               end else begin
                  state <= ST_C;
               end
            end
            ST_C: begin
               sh_c  <= s_data;
               state <= s_last ? ST_A : ST_X;
            end
            ST_X: begin
               if (s_last) state <= ST_A;
            end
            default: state <= ST_A;
         endcase
      end
   end

   // Coefficients are copied from the shadows only alongside an x, so the
   // MAC never sees a new a/b/c paired with a stale sample.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_a     <= '0;
         in_b     <= '0;
         in_c     <= '0;
         in_x     <= '0;
         enable   <= 1'b0;
         eval_cnt <= '0;
      end else begin
         enable <= issue;
         if (issue) begin
            in_a     <= sh_a;
            in_b     <= sh_b;
            in_c     <= sh_c;
            in_x     <= s_data;
            eval_cnt <= eval_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_quad_operand_loader.sv
// Self-checking bench for quad_operand_loader: per-cycle comparison against a
// frame-position model plus directed scenarios with literal expectations.
module tb_quad_operand_loader;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] s_data = 8'd0;
   logic       s_valid = 1'b0;
   logic       s_last = 1'b0;
   logic       stall = 1'b0;
   logic       s_ready;
   logic [7:0] in_a, in_b, in_c, in_x;
   logic       enable;
   logic [7:0] eval_cnt;
   logic       err;
   logic       busy;

   quad_operand_loader #(.DATA_W(8), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
      .s_last(s_last), .s_ready(s_ready), .stall(stall),
      .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_x(in_x),
      .enable(enable), .eval_cnt(eval_cnt), .err(err), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit rand_stall = 1'b0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: pos counts bytes into the current frame (3 means "in the x samples").
   int         pos;
   logic [7:0] ma, mb, mc, ea, eb, ec, ex, ecnt;
   logic       een, eerr;
   bit         m_ready, m_fire;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         pos = 0; ma = 0; mb = 0; mc = 0;
         ea = 0; eb = 0; ec = 0; ex = 0; ecnt = 0; een = 0; eerr = 0;
      end else begin
         m_ready = (pos < 3) || !stall;
         m_fire  = s_valid && m_ready;
         een = 0;
         if (m_fire) begin
            if (pos == 0)      ma = s_data;
            else if (pos == 1) mb = s_data;
            else if (pos == 2) mc = s_data;
            else begin
               ea = ma; eb = mb; ec = mc; ex = s_data;
               een = 1; ecnt = ecnt + 8'd1;
            end
            if (s_last) begin
               if (pos < 2) eerr = 1;
               pos = 0;
            end else if (pos < 3) begin
               pos++;
            end
         end
      end
   end

   typedef struct {
      logic [7:0] a, b, c, x, cnt;
      int         cyc;
   } pulse_t;
   pulse_t cap[$];

   always @(negedge clk) begin
      if (reset) begin
         check("s_ready", s_ready, (pos < 3) || !stall);
         check("enable", enable, een);
         check("in_a", in_a, ea);
         check("in_b", in_b, eb);
         check("in_c", in_c, ec);
         check("in_x", in_x, ex);
         check("eval_cnt", eval_cnt, ecnt);
         check("err", err, eerr);
         check("busy", busy, pos != 0);
         if (enable) cap.push_back('{a: in_a, b: in_b, c: in_c, x: in_x, cnt: eval_cnt, cyc: cyc});
      end
   end

   task automatic idle(input int n);
      s_valid = 1'b0;
      repeat (n) begin
         if (rand_stall) stall = ($urandom % 3 == 0);
         @(posedge clk); #1;
      end
   endtask

   task automatic send(input logic [7:0] d, input bit l);
      bit acc;
      int n;
      s_data = d; s_last = l; s_valid = 1'b1; n = 0;
      do begin
         if (rand_stall) stall = ($urandom % 3 == 0);
         @(negedge clk);
         acc = s_ready;
         @(posedge clk); #1;
         n++;
      end while (!acc && n < 200);
      if (!acc) begin
         checks++; errors++;
         $display("FAIL send_accept: byte %0d not accepted within %0d cycles", d, n);
      end
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      s_valid = 1'b0; stall = 1'b0;
      reset = 1'b0;
      #1;
      check("rst_s_ready", s_ready, 0);
      check("rst_enable", enable, 0);
      check("rst_in_a", in_a, 0);
      check("rst_in_b", in_b, 0);
      check("rst_in_c", in_c, 0);
      check("rst_in_x", in_x, 0);
      check("rst_eval_cnt", eval_cnt, 0);
      check("rst_err", err, 0);
      check("rst_busy", busy, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      cap.delete();
   endtask

   task automatic chk_pulse(input string name, input int idx, input int a, input int b,
                            input int c, input int x, input int cnt);
      if (cap.size() <= idx) begin
         checks++; errors++;
         $display("FAIL %s: pulse %0d missing, got %0d pulses", name, idx, cap.size());
      end else begin
         check({name, "_a"}, cap[idx].a, a);
         check({name, "_b"}, cap[idx].b, b);
         check({name, "_c"}, cap[idx].c, c);
         check({name, "_x"}, cap[idx].x, x);
         check({name, "_cnt"}, cap[idx].cnt, cnt);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit exceeded");
      $fatal(1);
   end

   initial begin
      int drop;
      int gaps;
      int mac;
      #2 reset = 1'b0;
      #1;
      check("init_s_ready", s_ready, 0);
      check("init_enable", enable, 0);
      check("init_eval_cnt", eval_cnt, 0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check("release_s_ready", s_ready, 1);
      @(posedge clk); #1;

      // Single-sample frame
      do_reset();
      send(5, 0); send(13, 0); send(7, 0); send(8, 1);
      idle(3);
      check("f1_pulses", cap.size(), 1);
      chk_pulse("f1", 0, 5, 13, 7, 8, 1);
      if (cap.size() > 0) begin
         mac = int'(cap[0].a) * int'(cap[0].x) * int'(cap[0].x) + int'(cap[0].b) * int'(cap[0].x) + int'(cap[0].c);
         check("f1_mac", mac, 431);
      end
      check("f1_busy", busy, 0);

      // Back-to-back samples
      do_reset();
      send(1, 0); send(2, 0); send(3, 0); send(0, 0); send(4, 0); send(9, 1);
      idle(3);
      check("f2_pulses", cap.size(), 3);
      chk_pulse("f2p0", 0, 1, 2, 3, 0, 1);
      chk_pulse("f2p1", 1, 1, 2, 3, 4, 2);
      chk_pulse("f2p2", 2, 1, 2, 3, 9, 3);
      if (cap.size() == 3) begin
         check("f2_adj01", cap[1].cyc - cap[0].cyc, 1);
         check("f2_adj12", cap[2].cyc - cap[1].cyc, 1);
      end
      check("f2_cnt", eval_cnt, 3);

      // Stall holds the sample for three cycles
      do_reset();
      send(25, 0); send(18, 0); send(10, 0);
      s_data = 4; s_last = 1; s_valid = 1; stall = 1;
      repeat (3) begin
         @(negedge clk);
         check("f3_stall_ready", s_ready, 0);
         check("f3_stall_enable", enable, 0);
         @(posedge clk); #1;
      end
      stall = 0;
      drop = cyc;
      @(negedge clk);
      check("f3_ready_back", s_ready, 1);
      @(posedge clk); #1;
      s_valid = 0; s_last = 0;
      idle(2);
      check("f3_pulses", cap.size(), 1);
      chk_pulse("f3", 0, 25, 18, 10, 4, 1);
      if (cap.size() > 0) check("f3_latency", cap[0].cyc - drop, 1);

      // Framing error, then recovery
      do_reset();
      send(10, 0); send(5, 1);
      idle(2);
      check("f4_err", err, 1);
      check("f4_no_pulse", cap.size(), 0);
      send(1, 0); send(1, 0); send(1, 0); send(2, 1);
      idle(2);
      check("f4_pulses", cap.size(), 1);
      chk_pulse("f4", 0, 1, 1, 1, 2, 1);
      check("f4_err_sticky", err, 1);

      // Reset mid-frame after two issues
      do_reset();
      send(7, 0); send(7, 0); send(7, 0); send(1, 0); send(2, 0);
      idle(1);
      check("f5_cnt_pre", eval_cnt, 2);
      check("f5_busy_pre", busy, 1);
      do_reset();
      send(3, 0); send(4, 0); send(5, 0); send(6, 1);
      idle(2);
      check("f5_pulses", cap.size(), 1);
      chk_pulse("f5", 0, 3, 4, 5, 6, 1);

      // Counter wrap over 256 samples
      do_reset();
      send(1, 0); send(1, 0); send(1, 0);
      for (int i = 0; i < 256; i++) send(8'(i), i == 255);
      idle(2);
      check("f6_pulses", cap.size(), 256);
      check("f6_cnt_wrap", eval_cnt, 0);
      if (cap.size() == 256) begin
         gaps = 0;
         for (int i = 1; i < 256; i++) if (cap[i].cyc != cap[i-1].cyc + 1) gaps++;
         check("f6_gaps", gaps, 0);
         check("f6_last_cnt", cap[255].cnt, 0);
         check("f6_prev_cnt", cap[254].cnt, 255);
         check("f6_last_x", cap[255].x, 255);
      end

      // Randomised frames with gaps, stalls and occasional short frames
      do_reset();
      rand_stall = 1'b1;
      for (int f = 0; f < 60; f++) begin
         int nb;
         nb = $urandom_range(1, 12);
         for (int j = 0; j < nb; j++) begin
            idle($urandom % 3);
            send(8'($urandom), j == nb - 1);
         end
      end
      rand_stall = 1'b0;
      stall = 1'b0;
      idle(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/quad_operand_loader.md
Name: quad_operand_loader

Overview:
- Upstream feeder for the Quadratic_Equation MAC.
- Accepts an 8-bit byte stream over a valid/ready handshake, organised as frames: coefficients a, b, c, then one or more x samples.
- Drives in_a/in_x/in_b/in_c and a one-cycle enable per x sample; coefficient outputs change atomically with x.
- Also provides a wrapping issue counter and a sticky framing-error flag.

Parameters:
- DATA_W, 8, width of stream bytes and of each operand output.
- CNT_W, 8, width of the eval_cnt issue counter.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- s_data  in  DATA_W  stream byte.
- s_valid  in  1  s_data valid.
- s_last  in  1  marks the final byte of a frame.
- s_ready  out  1  loader can accept the byte.
- stall  in  1  downstream hold; no new issue while 1.
- in_a  out  DATA_W  coefficient a to MAC.
- in_b  out  DATA_W  coefficient b to MAC.
- in_c  out  DATA_W  coefficient c to MAC.
- in_x  out  DATA_W  sample x to MAC.
- enable  out  1  one-cycle issue strobe to MAC.
- eval_cnt  out  CNT_W  count of issued samples.
- err  out  1  sticky framing error.
- busy  out  1  high when state != ST_A.

Behaviour:
- Reset (reset=0, async):
  - state=ST_A; shadow a/b/c=0.
  - in_a, in_b, in_c, in_x = 0; enable=0; eval_cnt=0; err=0.
  - s_ready=0 while reset=0; s_ready=1 from the first cycle after release.
- fire = s_valid & s_ready. All state/register updates happen on clk rising edge, on fire only.
- s_ready:
  - 1 in ST_A, ST_B, ST_C (stall ignored).
  - In ST_X, s_ready = ~stall (combinational).
- FSM:
  - ST_A, fire: sh_a<=s_data.
    - s_last=0 -> ST_B.
    - s_last=1 -> err<=1, stay ST_A.
  - ST_B, fire: sh_b<=s_data.
    - s_last=0 -> ST_C.
    - s_last=1 -> err<=1, -> ST_A.
  - ST_C, fire: sh_c<=s_data.
    - s_last=0 -> ST_X.
    - s_last=1 -> ST_A, no issue, no error. Coefficient-only frame; shadows are discarded at the next frame.
  - ST_X, fire: issue, then:
    - s_last=1 -> ST_A.
    - s_last=0 -> stay ST_X.
- Issue (registered, latency 1 from the fire edge):
  - On the next edge: in_x<=s_data; in_a/in_b/in_c<=sh_a/sh_b/sh_c; enable<=1; eval_cnt<=eval_cnt+1.
  - eval_cnt wraps 2^CNT_W-1 -> 0 silently.
- enable:
  - 1 for exactly one cycle per issue; consecutive fires give back-to-back pulses (one sample per clock max).
  - Deasserts the cycle after the last issue.
- Operand outputs hold their value between issues and change only in a cycle where enable=1. New coefficients never appear on in_a/b/c before their first x.
- stall:
  - stall=1 in ST_X -> s_ready=0, no issue.
  - A pulse already registered (fired the cycle before stall rose) still appears; stall does not cancel it.
- Simultaneous events:
  - stall is sampled in the same cycle as s_valid; no skid buffer.
  - s_valid with s_ready=0 is ignored; the upstream holds the byte.
- Reset mid-frame: partial frame dropped; outputs return to reset values immediately (async).
- err stays set until reset. The frame that raised err is discarded; parsing resumes at ST_A with the next byte treated as a.
- No arithmetic is done here; widths pass through unchanged.

Decomposition:
- Shared package quad_pkg:
  - DATA_W default.
  - State enum {ST_A, ST_B, ST_C, ST_X}, 2-bit encoding.
  - Also consumed by the MAC bench.
- No sub-module is natural. The shadow registers and issue register are a few flops; one module, one FSM process plus a registered output process.

Test Plan:
- Frame 5,13,7,8(last), stall=0:
  - Exactly one enable pulse, with in_a=5, in_b=13, in_c=7, in_x=8.
  - eval_cnt=1; state back to ST_A.
  - Downstream MAC result 431.
- Frame 1,2,3,0,4,9(last), back-to-back valid:
  - Three consecutive enable cycles with in_x=0,4,9 and a/b/c=1/2/3 on each.
  - eval_cnt=3.
- Frame 25,18,10, then x=4 with stall=1 for 3 cycles, then stall=0:
  - s_ready=0 during the stall; no enable.
  - One pulse (a=25, x=4, b=18, c=10) one cycle after the stall drops.
- s_last on the 2nd byte (10, 5-last), then a good frame 1,1,1,2(last):
  - err=1; no enable for the bad frame.
  - Good frame issues x=2 with a/b/c=1; err stays 1.
- reset driven low in ST_X mid-frame (after 2 x issued):
  - All outputs 0 immediately; eval_cnt=0; err=0.
  - After release the next byte is parsed as a.
- 256 x samples in one frame (CNT_W=8): eval_cnt wraps to 0 after the 256th issue; enable pulses continuously.
